des_key_schedule: RTL and testbench

Upstream of the DES Feistel round function. Accepts a 64-bit DES key and emits the sixteen 48-bit round keys K1..K16 one at a time over a valid/ready stream, in the order the round engine consumes them. The key order is K1..K16 for encryption and K16..K1 for decryption. It holds the 28-bit C/D halves in registers and rotates them once per accepted round key, so no round-key RAM is needed.

---
 rtl/des_key_schedule.sv | 185 ++++++++++++++++++
 tb/tb_des_key_schedule.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//
// Produces the sixteen 48-bit DES round keys from a 64-bit key, one per
// accepted valid/ready transfer. Only the 28-bit C/D halves are stored; each
// accepted key rotates them into the next round's value, so there is no
// round-key RAM. Encrypt order is K1..K16, decrypt order is K16..K1.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           start a schedule (only honoured while o_busy=0)
//   i_key[63:0]      DES key, bit 63 = FIPS bit 1 (parity bits dropped by PC-1)
//   i_decrypt        sampled with i_load; 1 = emit K16..K1
//   i_abort          synchronous return to IDLE, highest priority
//   o_busy           schedule in progress
//   o_rk_valid       o_round_key is valid
//   i_rk_ready       consumer accepts the current key
//   o_round_key[47:0] current round key, bit 47 = FIPS bit 1
//   o_round[3:0]     position of the current key in emission order
//   o_done           one-cycle pulse after the 16th key is accepted
//   o_parity_err     key parity flag
//
// Optional build macro: DES_KS_PARITY_CHECK_EN
//   defined   -> o_parity_err flags any key byte with even parity (advisory)
//   undefined -> o_parity_err is tied low, no parity logic
// -----------------------------------------------------------------------------
module des_key_schedule (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_rk_valid,
  input  logic        i_rk_ready,
  output logic [47:0] o_round_key,
  output logic [3:0]  o_round,
  output logic        o_done,
  output logic        o_parity_err
);

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q;
  logic        dir_q;
  logic [3:0]  round_q;
  logic        done_q;
  logic        rk_xfer;
  logic        load_acc;
  logic        enc_two, dec_two;
  logic [55:0] pc1_key;

  // Table positions are 1-based FIPS bit numbers counted from the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = key[6'(64 - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    return r;
  endfunction

  // Schedule step idx (1..16) rotates by one for steps 1, 2, 9 and 16, else by two.
  function automatic logic shift_is_two(input logic [4:0] idx);
    return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign rk_xfer  = (state == ISSUE) && i_rk_ready;
  assign load_acc = (state == IDLE) && i_load && !i_abort;
  assign pc1_key  = pc1(i_key);

  // Emitting key r: encrypt moves on to K(r+2), decrypt steps back from K(16-r).
  assign enc_two = shift_is_two(5'({1'b0, round_q}) + 5'd2);
  assign dec_two = shift_is_two(5'd16 - 5'({1'b0, round_q}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_load) state_nxt = ISSUE;
      ISSUE: if (rk_xfer && round_q == 4'd15) state_nxt = IDLE;
    endcase
    if (i_abort) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= !i_abort && rk_xfer && (round_q == 4'd15);
      if (i_abort) begin
        round_q <= '0;
      end else if (load_acc) begin
        // C0D0 already equals C16D16, so decrypt starts unrotated.
        if (i_decrypt) begin
          c_q <= pc1_key[55:28];
          d_q <= pc1_key[27:0];
        end else begin
          c_q <= rotl(pc1_key[55:28], 1'b0);
          d_q <= rotl(pc1_key[27:0], 1'b0);
        end
        dir_q   <= i_decrypt;
        round_q <= '0;
      end else if (rk_xfer) begin
        if (round_q != 4'd15) begin
          round_q <= round_q + 4'd1;
          if (dir_q) begin
            c_q <= rotr(c_q, dec_two);
            d_q <= rotr(d_q, dec_two);
          end else begin
            c_q <= rotl(c_q, enc_two);
            d_q <= rotl(d_q, enc_two);
          end
        end else begin
          round_q <= '0;
        end
      end
    end
  end

  assign o_busy      = (state == ISSUE);
  assign o_rk_valid  = (state == ISSUE);
  assign o_round_key = pc2({c_q, d_q});
  assign o_round     = round_q;
  assign o_done      = done_q;

`ifdef DES_KS_PARITY_CHECK_EN
  logic par_err_q;
  logic key_par_bad;

  // Every byte must carry odd parity; an even byte reduces to 0.
  assign key_par_bad = ~&{^i_key[63:56], ^i_key[55:48], ^i_key[47:40], ^i_key[39:32],
                          ^i_key[31:24], ^i_key[23:16], ^i_key[15:8],  ^i_key[7:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      par_err_q <= 1'b0;
    else if (i_abort)  par_err_q <= 1'b0;
    else if (load_acc) par_err_q <= key_par_bad;
  end

  assign o_parity_err = par_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_load;
  logic [63:0] i_key;
  logic        i_decrypt;
  logic        i_abort;
  logic        o_busy;
  logic        o_rk_valid;
  logic        i_rk_ready;
  logic [47:0] o_round_key;
  logic [3:0]  o_round;
  logic        o_done;
  logic        o_parity_err;

  int tests = 0;
  int fails = 0;

  // Round keys K1..K16 for key 0x133457799BBCDFF1, worked out by hand.
  logic [47:0] k_tbl [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  logic [47:0] exp_key_q [$];
  logic [3:0]  exp_rnd_q [$];

  des_key_schedule dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (i_load),
    .i_key       (i_key),
    .i_decrypt   (i_decrypt),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_rk_valid  (o_rk_valid),
    .i_rk_ready  (i_rk_ready),
    .o_round_key (o_round_key),
    .o_round     (o_round),
    .o_done      (o_done),
    .o_parity_err(o_parity_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected key per transfer and checks stall stability.
  logic        prev_stall = 1'b0;
  logic [47:0] prev_key;
  logic [3:0]  prev_rnd;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (prev_stall && o_rk_valid) begin
        check("stall_key_stable", 64'(o_round_key), 64'(prev_key));
        check("stall_round_stable", 64'(o_round), 64'(prev_rnd));
      end
      if (o_rk_valid && i_rk_ready && !i_abort) begin
        if (exp_key_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_transfer: got key %h round %0d, expected none",
                   o_round_key, o_round);
        end else begin
          check("round_key", 64'(o_round_key), 64'(exp_key_q.pop_front()));
          check("round_idx", 64'(o_round), 64'(exp_rnd_q.pop_front()));
        end
      end
    end
    prev_stall = i_rst_n && o_rk_valid && !i_rk_ready && !i_abort;
    prev_key   = o_round_key;
    prev_rnd   = o_round;
  end

  task automatic push_expected(input bit dec);
    for (int i = 0; i < 16; i++) begin
      exp_key_q.push_back(dec ? k_tbl[15 - i] : k_tbl[i]);
      exp_rnd_q.push_back(4'(i));
    end
  endtask

  task automatic do_load(input logic [63:0] key, input bit dec);
    i_load    = 1'b1;
    i_key     = key;
    i_decrypt = dec;
    @(posedge i_clk);
    #1;
    i_load = 1'b0;
  endtask

  // Runs one schedule. inj_load_at/abort_at >= 0 inject a load or abort while
  // that round index is presented; exp_cycles < 0 skips the throughput check.
  task automatic run_sched(input logic [63:0] key, input bit dec, input bit rnd,
                           input int inj_load_at, input int abort_at,
                           input int exp_cycles, input bit exp_par);
    int  cycles;
    bit  got_done;
    bit  aborting;
    push_expected(dec);
    i_rk_ready = 1'b1;
    do_load(key, dec);
    check("first_valid", 64'(o_rk_valid), 64'd1);
    check("first_round", 64'(o_round), 64'd0);
    check("first_key", 64'(o_round_key), 64'(dec ? k_tbl[15] : k_tbl[0]));
    cycles   = 0;
    got_done = 1'b0;
    aborting = 1'b0;
    while (!got_done && cycles < 200) begin
      i_load     = 1'b0;
      i_abort    = 1'b0;
      i_rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (o_rk_valid && int'(o_round) == inj_load_at) begin
        i_load    = 1'b1;
        i_key     = 64'hFEDCBA9876543210;
        i_decrypt = !dec;
      end
      if (o_rk_valid && int'(o_round) == abort_at) begin
        i_abort    = 1'b1;
        i_rk_ready = 1'b1;
        aborting   = 1'b1;
      end
      @(posedge i_clk);
      #1;
      cycles++;
      if (aborting) begin
        i_abort = 1'b0;
        check("abort_valid", 64'(o_rk_valid), 64'd0);
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_round", 64'(o_round), 64'd0);
        check("abort_done", 64'(o_done), 64'd0);
        check("abort_left", 64'(exp_key_q.size()), 64'(16 - abort_at));
        exp_key_q.delete();
        exp_rnd_q.delete();
        @(posedge i_clk);
        #1;
        check("abort_no_done", 64'(o_done), 64'd0);
        return;
      end
      if (o_done) got_done = 1'b1;
    end
    i_load = 1'b0;
    if (!got_done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no o_done in %0d cycles, expected one", cycles);
      exp_key_q.delete();
      exp_rnd_q.delete();
      return;
    end
    check("done_after_16", 64'(exp_key_q.size()), 64'd0);
    check("done_busy", 64'(o_busy), 64'd0);
    check("done_valid", 64'(o_rk_valid), 64'd0);
    check("parity_err", 64'(o_parity_err), 64'(exp_par));
    if (exp_cycles >= 0) check("throughput_cycles", 64'(cycles), 64'(exp_cycles));
    @(posedge i_clk);
    #1;
    check("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  initial begin
    bit par_on;
`ifdef DES_KS_PARITY_CHECK_EN
    par_on = 1'b1;
`else
    par_on = 1'b0;
`endif
    i_rst_n    = 1'b0;
    i_load     = 1'b0;
    i_key      = '0;
    i_decrypt  = 1'b0;
    i_abort    = 1'b0;
    i_rk_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_rk_valid), 64'd0);
    check("rst_key", 64'(o_round_key), 64'd0);
    check("rst_round", 64'(o_round), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_parity", 64'(o_parity_err), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Encrypt and decrypt at full rate.
    run_sched(KEY_A, 1'b0, 1'b0, -1, -1, 16, 1'b0);
    run_sched(KEY_A, 1'b1, 1'b0, -1, -1, 16, 1'b0);

    // Random back-pressure.
    run_sched(KEY_A, 1'b0, 1'b1, -1, -1, -1, 1'b0);

    // Load while busy is ignored.
    run_sched(KEY_A, 1'b0, 1'b0, 5, -1, 16, 1'b0);

    // Abort mid-schedule, then a reload starts from K1.
    run_sched(KEY_A, 1'b0, 1'b0, -1, 9, -1, 1'b0);
    run_sched(KEY_A, 1'b0, 1'b0, -1, -1, 16, 1'b0);

    // Asynchronous reset mid-schedule.
    push_expected(1'b0);
    i_rk_ready = 1'b1;
    do_load(KEY_A, 1'b0);
    for (int i = 0; i < 40 && o_round != 4'd7; i++) begin
      @(posedge i_clk);
      #1;
    end
    check("pre_reset_round", 64'(o_round), 64'd7);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_valid", 64'(o_rk_valid), 64'd0);
    check("arst_key", 64'(o_round_key), 64'd0);
    check("arst_round", 64'(o_round), 64'd0);
    check("arst_done", 64'(o_done), 64'd0);
    check("arst_left", 64'(exp_key_q.size()), 64'd9);
    exp_key_q.delete();
    exp_rnd_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Parity: a flipped parity bit leaves the round keys unchanged.
    run_sched(KEY_BAD, 1'b0, 1'b0, -1, -1, 16, par_on);
    check("parity_hold", 64'(o_parity_err), 64'(par_on));
    run_sched(KEY_A, 1'b1, 1'b0, -1, -1, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
